// File: rtl/pipe_stall_ctrl.sv
// Fetch-side pipeline stall/flush controller: PC register, IF/ID register, ID/EX bubble flag.
// Define PIPE_STALL_STATS_EN to build the HOLD/FLUSH event counters; otherwise they read as 0.
module pipe_stall_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_shouldstall,
   input  logic [1:0]  IF_shouldstall,
   input  logic        ID_shouldstall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] imem_inst,
   output logic [31:0] pc_out,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc,
   output logic        ifid_valid,
   output logic        idex_bubble,
   output logic [1:0]  pipe_state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StHold  = 2'b01,
      StFlush = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        idex_bubble_q;
   logic        flush_now;
   logic        hold_now;

   // A taken branch squashes the wrong-path fetch no matter what the hazard unit asked for.
   assign flush_now = branch_taken | IF_shouldstall[1];
   assign hold_now  = (IF_shouldstall == 2'b01) | PC_shouldstall;

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (branch_taken) begin
         pc_d = branch_target;
      end else if (PC_shouldstall) begin
         pc_d = pc_q;
      end
   end

   always_comb begin
      ifid_inst_d  = ifid_inst_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      if (flush_now) begin
         ifid_inst_d  = NOP_INST;
         ifid_pc_d    = pc_q;
         ifid_valid_d = 1'b0;
      end else if (IF_shouldstall == 2'b00) begin
         ifid_inst_d  = imem_inst;
         ifid_pc_d    = pc_q;
         ifid_valid_d = 1'b1;
      end
   end

   always_comb begin
      state_d = StRun;
      if (flush_now) begin
         state_d = StFlush;
      end else if (hold_now) begin
         state_d = StHold;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         ifid_inst_q   <= NOP_INST;
         ifid_pc_q     <= 32'h0000_0000;
         ifid_valid_q  <= 1'b0;
         idex_bubble_q <= 1'b0;
         state_q       <= StRun;
      end else begin
         pc_q          <= pc_d;
         ifid_inst_q   <= ifid_inst_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_valid_q  <= ifid_valid_d;
         idex_bubble_q <= ID_shouldstall;
         state_q       <= state_d;
      end
   end

   assign pc_out      = pc_q;
   assign ifid_inst   = ifid_inst_q;
   assign ifid_pc     = ifid_pc_q;
   assign ifid_valid  = ifid_valid_q;
   assign idex_bubble = idex_bubble_q;
   assign pipe_state  = state_q;

`ifdef PIPE_STALL_STATS_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // Counted on the edge that lands in the state, saturating rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         if ((state_d == StHold) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if ((state_d == StFlush) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = 16'h0000;
   assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed steps push expected post-edge outputs,
// a monitor pops and compares after each rising edge.
module tb_pipe_stall_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I1  = 32'h2010_0001;
   localparam logic [31:0] I2  = 32'h2020_0002;
   localparam logic [31:0] I3  = 32'h3030_0003;
   localparam logic [31:0] I5  = 32'h5050_0005;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] ipc;
      logic        valid;
      logic        bub;
      logic [1:0]  st;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        PC_shouldstall = 1'b0;
   logic [1:0]  IF_shouldstall = 2'b00;
   logic        ID_shouldstall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] imem_inst = 32'h0;
   logic [31:0] pc_out, ifid_inst, ifid_pc;
   logic        ifid_valid, idex_bubble;
   logic [1:0]  pipe_state;
   logic [15:0] stall_cnt, flush_cnt;

   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;
   exp_t q[$];

   pipe_stall_ctrl #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (NOP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .PC_shouldstall (PC_shouldstall),
      .IF_shouldstall (IF_shouldstall),
      .ID_shouldstall (ID_shouldstall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_inst      (imem_inst),
      .pc_out         (pc_out),
      .ifid_inst      (ifid_inst),
      .ifid_pc        (ifid_pc),
      .ifid_valid     (ifid_valid),
      .idex_bubble    (idex_bubble),
      .pipe_state     (pipe_state),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] ipc, input logic valid, input logic bub,
                               input logic [1:0] st, input logic [15:0] sc,
                               input logic [15:0] fc);
      exp_t e;
      e.pc = pc; e.inst = inst; e.ipc = ipc; e.valid = valid; e.bub = bub; e.st = st;
`ifdef PIPE_STALL_STATS_EN
      e.sc = sc; e.fc = fc;
`else
      e.sc = (sc == 16'h0) ? 16'h0 : 16'h0;
      e.fc = (fc == 16'h0) ? 16'h0 : 16'h0;
`endif
      return e;
   endfunction

   task automatic chk(input string name, input int tag, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, tag, act, req);
      end
   endtask

   task automatic chk_all(input int tag, input exp_t e);
      chk("pc_out", tag, pc_out, e.pc);
      chk("ifid_inst", tag, ifid_inst, e.inst);
      chk("ifid_pc", tag, ifid_pc, e.ipc);
      chk("ifid_valid", tag, {31'h0, ifid_valid}, {31'h0, e.valid});
      chk("idex_bubble", tag, {31'h0, idex_bubble}, {31'h0, e.bub});
      chk("pipe_state", tag, {30'h0, pipe_state}, {30'h0, e.st});
      chk("stall_cnt", tag, {16'h0, stall_cnt}, {16'h0, e.sc});
      chk("flush_cnt", tag, {16'h0, flush_cnt}, {16'h0, e.fc});
   endtask

   task automatic drive(input logic pcs, input logic [1:0] ifs, input logic ids,
                        input logic bt, input logic [31:0] tgt, input logic [31:0] imem,
                        input exp_t e);
      PC_shouldstall = pcs;
      IF_shouldstall = ifs;
      ID_shouldstall = ids;
      branch_taken   = bt;
      branch_target  = tgt;
      imem_inst      = imem;
      q.push_back(e);
   endtask

   task automatic step(input logic pcs, input logic [1:0] ifs, input logic ids,
                       input logic bt, input logic [31:0] tgt, input logic [31:0] imem,
                       input exp_t e);
      @(negedge clk);
      drive(pcs, ifs, ids, bt, tgt, imem, e);
   endtask

   // Monitor: one expected entry per rising edge while stimulus is outstanding.
   always @(posedge clk) begin
      #2;
      if (q.size() > 0) begin
         step_no++;
         chk_all(step_no, q.pop_front());
      end
   end

   initial begin
      #1 rst_n = 1'b0;
      #1 chk_all(0, mk(32'h0, NOP, 32'h0, 1'b0, 1'b0, 2'b00, 16'd0, 16'd0));
      repeat (2) @(posedge clk);

      // Release and straight-line fetch.
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I1, mk(32'h4, I1, 32'h0, 1, 0, 2'b00, 0, 0));
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I1, mk(32'h8, I1, 32'h4, 1, 0, 2'b00, 0, 0));
      // Two-cycle hold at pc 8 with ID bubble.
      step(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, I2, mk(32'h8, I1, 32'h4, 1, 1, 2'b01, 1, 0));
      step(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, I2, mk(32'h8, I1, 32'h4, 1, 1, 2'b01, 2, 0));
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I2, mk(32'hC, I2, 32'h8, 1, 0, 2'b00, 2, 0));
      // PC held but IF/ID still loads.
      step(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, I3, mk(32'hC, I3, 32'hC, 1, 0, 2'b01, 3, 0));
      // Branch overrides both PC hold and IF hold.
      step(1'b1, 2'b01, 1'b0, 1'b1, 32'h40, I3, mk(32'h40, NOP, 32'hC, 0, 0, 2'b10, 3, 1));
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I5, mk(32'h44, I5, 32'h40, 1, 0, 2'b00, 3, 1));
      // Back-to-back flush requests via IF codes 10 and 11.
      step(1'b0, 2'b10, 1'b0, 1'b0, 32'h0, I5, mk(32'h48, NOP, 32'h44, 0, 0, 2'b10, 3, 2));
      step(1'b0, 2'b11, 1'b0, 1'b0, 32'h0, I5, mk(32'h4C, NOP, 32'h48, 0, 0, 2'b10, 3, 3));
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I5, mk(32'h50, I5, 32'h4C, 1, 0, 2'b00, 3, 3));
      // PC wrap at the top of the address space.
      step(1'b0, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFC, I5,
           mk(32'hFFFF_FFFC, NOP, 32'h50, 0, 0, 2'b10, 3, 4));
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I5,
           mk(32'h0, I5, 32'hFFFF_FFFC, 1, 0, 2'b00, 3, 4));
      // Lone ID bubble: one-cycle latency, no effect on fetch.
      step(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, I5, mk(32'h4, I5, 32'h0, 1, 1, 2'b00, 3, 4));
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I5, mk(32'h8, I5, 32'h4, 1, 0, 2'b00, 3, 4));
      step(1'b1, 2'b01, 1'b0, 1'b0, 32'h0, I1, mk(32'h8, I5, 32'h4, 1, 0, 2'b01, 4, 4));

      // Asynchronous reset mid-HOLD, checked before any further clock edge.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_all(100, mk(32'h0, NOP, 32'h0, 1'b0, 1'b0, 2'b00, 16'd0, 16'd0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I2, mk(32'h4, I2, 32'h0, 1, 0, 2'b00, 0, 0));
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, I2, mk(32'h8, I2, 32'h4, 1, 0, 2'b00, 0, 0));

      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0000, instruction word injected on flush/bubble.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 PC_shouldstall  input  1  hold PC this cycle.
REQ-006 IF_shouldstall  input  2  IF/ID action: 00 load, 01 hold, 10 flush, 11 flush.
REQ-007 ID_shouldstall  input  1  insert bubble into ID/EXE.
REQ-008 branch_taken  input  1  branch/jump resolved taken this cycle.
REQ-009 branch_target  input  32  PC to load when branch_taken=1.
REQ-010 imem_inst  input  32  instruction fetched at pc_out.
REQ-011 pc_out  output  32  current fetch PC.
REQ-012 ifid_inst  output  32  IF/ID instruction register.
REQ-013 ifid_pc  output  32  IF/ID PC register (PC of ifid_inst).
REQ-014 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-015 idex_bubble  output  1  registered: ID/EXE must load NOP controls this cycle.
REQ-016 pipe_state  output  2  FSM state: 00 RUN, 01 HOLD, 10 FLUSH.
REQ-017 stall_cnt  output  16  total HOLD cycles (stats build only, else 0).
REQ-018 flush_cnt  output  16  total FLUSH events (stats build only, else 0).

Function
REQ-019 PC next value SHALL be: branch_target if branch_taken=1; else pc_out if PC_shouldstall=1; else pc_out+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-020 branch_taken SHALL override PC_shouldstall in the same cycle.
REQ-021 IF_shouldstall=00: ifid_inst<=imem_inst, ifid_pc<=pc_out, ifid_valid<=1.
REQ-022 IF_shouldstall=01: IF/ID registers SHALL hold their values.
REQ-023 IF_shouldstall=1x: ifid_inst<=NOP_INST, ifid_pc<=pc_out, ifid_valid<=0.
REQ-024 branch_taken=1 SHALL force flush of IF/ID regardless of IF_shouldstall.
REQ-025 idex_bubble SHALL equal ID_shouldstall registered one cycle (latency 1).
REQ-026 FSM next state: FLUSH if IF/ID flushed this cycle; else HOLD if IF_shouldstall=01 or PC_shouldstall=1; else RUN.
REQ-027 FLUSH SHALL last exactly one cycle unless a new flush condition occurs.
REQ-028 HOLD SHALL persist every cycle its condition holds, with no cycle limit.
REQ-029 PC_shouldstall=1 with IF_shouldstall=00 SHALL still load IF/ID (re-fetch of same PC permitted).
REQ-030 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-031 rst_n=0 SHALL immediately set pc_out=RESET_PC, ifid_inst=NOP_INST, ifid_pc=0, ifid_valid=0, idex_bubble=0, pipe_state=RUN, stall_cnt=0, flush_cnt=0.
REQ-032 Reset asserted mid-HOLD or mid-FLUSH SHALL abandon the operation; first edge after deassert SHALL behave as RUN from RESET_PC.

Configuration
REQ-033 Macro PIPE_STALL_STATS_EN defined: stall_cnt increments each cycle pipe_state enters/stays HOLD, flush_cnt each cycle it enters FLUSH; both saturate at 16'hFFFF.
REQ-034 Macro undefined: counters SHALL not be synthesized; stall_cnt and flush_cnt tied to 0.

Verification
REQ-035 Reset release, all stalls 0, imem_inst=32'h2010_0001 for 3 cycles -> pc_out 0,4,8,12; ifid_valid=1; pipe_state=RUN.
REQ-036 At pc_out=8: PC_shouldstall=1, IF=01, ID=1 for 2 cycles -> pc_out stays 8, ifid_inst held, idex_bubble=1 one cycle later for 2 cycles, pipe_state=HOLD, stall_cnt=2 (stats build).
REQ-037 branch_taken=1, branch_target=32'h40, PC_shouldstall=1, IF=01 -> next pc_out=32'h40, ifid_inst=NOP_INST, ifid_valid=0, pipe_state=FLUSH then RUN, flush_cnt=1.
REQ-038 pc_out=32'hFFFF_FFFC, no stall -> next pc_out=0.
REQ-039 rst_n pulsed low mid-HOLD -> outputs reset asynchronously without clock edge; resume fetch at RESET_PC.
REQ-040 Build without PIPE_STALL_STATS_EN, repeat REQ-036/037 -> stall_cnt=flush_cnt=0, all other responses identical.
